// File: rtl/decoder_3x8_seq.sv
// Sequenced 3-to-8 decoder.
// Codes arrive over a valid/ready handshake into a 2-entry FIFO. Each code is
// driven as a registered one-hot word on out and held for HOLD_CYCLES clocks.
// Queued codes follow back-to-back with no idle gap.
module decoder_3x8_seq #(
  parameter int HOLD_CYCLES = 4,   // legal range 1..255
  parameter int FIFO_DEPTH  = 2    // fixed at 2; pointers are a single bit
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [1:0] FULL_CNT  = 2'(FIFO_DEPTH);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  logic [2:0] fifo_mem [0:1];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic [2:0] head;

  logic [0:0] state;
  logic [7:0] cnt;

  // Binary code to one-hot word: bit i set iff code == i.
  function automatic logic [7:0] decode(input logic [2:0] code);
    decode = 8'd1 << code;
  endfunction

  // Readiness depends only on the registered count, so a same-cycle pop never
  // gates a push and there is no combinational path from the FSM to in_ready.
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign head     = fifo_mem[rd_ptr];

  // The FSM takes the head when idle, or when the current word's hold expires.
  assign pop  = (count != 2'd0) && ((state == IDLE) || (cnt == 8'd0));
  assign busy = (state == HOLD) | (count != 2'd0);

  // FIFO storage: data only, no reset needed since count qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_code;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as single bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output FSM: load a word, hold it for HOLD_CYCLES clocks, chain or go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      out       <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            out       <= decode(head);
            out_valid <= 1'b1;
            cnt       <= HOLD_LOAD;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (pop) begin
            out       <= decode(head);
            out_valid <= 1'b1;
            cnt       <= HOLD_LOAD;
          end else begin
            out       <= 8'h00;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out       <= 8'h00;
          out_valid <= 1'b0;
          cnt       <= 8'd0;
        end
      endcase
    end
  end

endmodule
